// File: rtl/jala_mem_pkg.sv
// Shared types and constants for the JALA memory arbiter.
//   state_t            : arbiter FSM states
//   REQ_FETCH/STACK/LOADER : fixed requester ids
//   AW_DEF/DW_DEF      : default address/data widths
package jala_mem_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

    localparam int unsigned REQ_FETCH  = 0;
    localparam int unsigned REQ_STACK  = 1;
    localparam int unsigned REQ_LOADER = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/jala_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   valid  : request vector
//   last   : id granted most recently (search starts at last+1)
//   onehot : one-hot pick, zero when nothing valid
//   id     : binary id of the pick
//   any    : at least one request valid
module jala_rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] id,
    output logic          any
);

    // Walk last+1, last+2, ... (mod N); the first valid requester wins.
    always_comb begin
        logic [IW-1:0] j;
        onehot = '0;
        id     = '0;
        any    = 1'b0;
        j      = '0;
        for (int unsigned d = 1; d <= N; d++) begin
            j = IW'((32'(last) + d) % N);
            if (!any && valid[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                id        = j;
            end
        end
    end

endmodule

// File: rtl/jala_mem_arbiter.sv
// Round-robin arbiter sharing the single-port JALA memory between N requesters
// (fetch, stack engine, program loader). One transaction in flight at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/ready/we/addr/wdata : per-requester valid/ready request channel
//   rsp_valid, rsp_rdata     : one-cycle completion pulse, shared read data
//   mem_en/we/addr/wdata/rdata : memory macro port
//   busy, grant_id           : status (not idle, current/last granted id)
module jala_mem_arbiter
    import jala_mem_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N-1:0]         req_we,
    input  logic [N*AW-1:0]      req_addr,
    input  logic [N*DW-1:0]      req_wdata,
    output logic [N-1:0]         rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = 3;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  last;
    logic           lat_we;
    logic [CW-1:0]  cnt;

    logic [N-1:0]   pick_onehot;
    logic [IW-1:0]  pick_id;
    logic           pick_any;

    jala_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid  (req_valid),
        .last   (last),
        .onehot (pick_onehot),
        .id     (pick_id),
        .any    (pick_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ACCESS;
            ACCESS:  state_nxt = lat_we ? RESP : WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; ready is only offered in IDLE and never while in reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (!rst) req_ready = pick_onehot;
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = lat_we;
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch, round-robin pointer, latency counter and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= IW'(N - 1);
            grant_id  <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            rsp_rdata <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                lat_we    <= req_we[pick_id];
                mem_addr  <= req_addr[32'(pick_id) * AW +: AW];
                mem_wdata <= req_wdata[32'(pick_id) * DW +: DW];
                grant_id  <= pick_id;
                last      <= pick_id;
            end
            if (state == ACCESS) begin
                cnt <= CW'(MEM_LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            // Counter reaches zero exactly MEM_LAT cycles after the mem_en cycle.
            if (state == WAIT && cnt == '0) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_jala_mem_arbiter.sv
module tb_jala_mem_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    int   cyc = 0;

    // Two lanes: lane 0 has MEM_LAT=1, lane 1 has MEM_LAT=3.
    logic        rst_l     [2];
    logic [2:0]  rv        [2];
    logic [2:0]  ready     [2];
    logic [2:0]  we_v      [2];
    logic [47:0] addr_v    [2];
    logic [47:0] wdata_v   [2];
    logic [2:0]  rspv      [2];
    logic [15:0] rdata     [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic        busy      [2];
    logic [1:0]  gid       [2];

    logic        env_init = 1'b1;
    logic [15:0] env_mem [2][256];
    logic [15:0] pipe    [2][8];

    txn_t txq  [6][$];
    int   glog [2][$];

    // Model state (transaction schedule in absolute cycle numbers).
    int          hs_at   [2];
    int          en_at   [2];
    int          rsp_at  [2];
    int          free_at [2];
    int          last_m  [2];
    int          gid_m   [2];
    int          cur_id  [2];
    logic        cur_we  [2];
    logic [15:0] cur_addr  [2];
    logic [15:0] cur_wdata [2];
    logic [15:0] hold    [2];
    int          hs_cnt  [2];
    logic [15:0] mdl_mem [2][256];

    int errs   = 0;
    int checks = 0;

    jala_mem_arbiter #(.N(3), .AW(16), .DW(16), .MEM_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst_l[0]),
        .req_valid(rv[0]), .req_ready(ready[0]), .req_we(we_v[0]),
        .req_addr(addr_v[0]), .req_wdata(wdata_v[0]),
        .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .grant_id(gid[0])
    );

    jala_mem_arbiter #(.N(3), .AW(16), .DW(16), .MEM_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst_l[1]),
        .req_valid(rv[1]), .req_ready(ready[1]), .req_we(we_v[1]),
        .req_addr(addr_v[1]), .req_wdata(wdata_v[1]),
        .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .grant_id(gid[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] h(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [15:0] dflt(input logic [7:0] i);
        return (i == 8'h28) ? 16'hBEEF : {i, ~i};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory macro: write on en&we, read data appears MEM_LAT cycles after en, junk otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (env_init) begin
                for (int i = 0; i < 256; i++) env_mem[k][i] <= dflt(8'(i));
            end else if (mem_en[k] && mem_we[k]) begin
                env_mem[k][h(mem_addr[k])] <= mem_wdata[k];
            end
            pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? env_mem[k][h(mem_addr[k])] : 16'hDEAD;
            for (int j = 1; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    // Requester drivers: present the head of each queue until the model sees it accepted.
    initial begin
        for (int k = 0; k < 2; k++) begin
            rv[k] = '0; we_v[k] = '0; addr_v[k] = '0; wdata_v[k] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 3; i++) begin
                    if (txq[k*3+i].size() > 0) begin
                        rv[k][i]              = 1'b1;
                        we_v[k][i]            = txq[k*3+i][0].we;
                        addr_v[k][i*16 +: 16]  = txq[k*3+i][0].addr;
                        wdata_v[k][i*16 +: 16] = txq[k*3+i][0].wdata;
                    end else begin
                        rv[k][i] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic void model_reset(input int k);
        hs_at[k] = -10; en_at[k] = -1; rsp_at[k] = -1; free_at[k] = 0;
        last_m[k] = 2; gid_m[k] = 0; cur_id[k] = 0; cur_we[k] = 1'b0;
        cur_addr[k] = '0; cur_wdata[k] = '0; hold[k] = '0;
    endfunction

    // Transaction-level model: a grant at cycle c schedules mem_en at c+1 and the
    // response at c+2 (write) or c+2+L (read); the arbiter is free again after that.
    task automatic model_step(input int k, input int lat);
        int          c;
        int          pick;
        int          j;
        logic [2:0]  e_ready;
        logic [2:0]  e_rsp;
        logic        e_en;
        txn_t        t;
        string       p;
        c = cyc;
        p = $sformatf("L%0d", k);
        if (c == rsp_at[k] && !cur_we[k]) hold[k] = mdl_mem[k][h(cur_addr[k])];
        e_ready = '0;
        pick    = -1;
        if (!rst_l[k] && c >= free_at[k] && rv[k] != 3'b000) begin
            for (int d = 1; d <= 3; d++) begin
                j = (last_m[k] + d) % 3;
                if (pick < 0 && rv[k][j]) pick = j;
            end
            e_ready[pick] = 1'b1;
        end
        e_en  = (c == en_at[k]);
        e_rsp = (c == rsp_at[k]) ? 3'(1 << cur_id[k]) : 3'b000;
        chk({p, " req_ready"}, 64'(ready[k]), 64'(e_ready));
        chk({p, " ready_onehot"}, 64'($countones(ready[k]) <= 1), 64'(1));
        chk({p, " mem_en"}, 64'(mem_en[k]), 64'(e_en));
        chk({p, " mem_we"}, 64'(mem_we[k]), 64'(e_en & cur_we[k]));
        chk({p, " mem_addr"}, 64'(mem_addr[k]), 64'(cur_addr[k]));
        chk({p, " mem_wdata"}, 64'(mem_wdata[k]), 64'(cur_wdata[k]));
        chk({p, " rsp_valid"}, 64'(rspv[k]), 64'(e_rsp));
        chk({p, " rsp_rdata"}, 64'(rdata[k]), 64'(hold[k]));
        chk({p, " busy"}, 64'(busy[k]), 64'((c > hs_at[k]) && (c < free_at[k])));
        chk({p, " grant_id"}, 64'(gid[k]), 64'(gid_m[k]));
        if (rst_l[k]) begin
            model_reset(k);
        end else if (pick >= 0 && txq[k*3+pick].size() > 0) begin
            t = txq[k*3+pick].pop_front();
            cur_id[k] = pick; cur_we[k] = t.we; cur_addr[k] = t.addr; cur_wdata[k] = t.wdata;
            hs_at[k]   = c;
            en_at[k]   = c + 1;
            rsp_at[k]  = t.we ? c + 2 : c + 2 + lat;
            free_at[k] = rsp_at[k] + 1;
            last_m[k]  = pick;
            gid_m[k]   = pick;
            if (t.we) mdl_mem[k][h(t.addr)] = t.wdata;
            glog[k].push_back(pick);
            hs_cnt[k]++;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            hs_cnt[k] = 0;
            for (int i = 0; i < 256; i++) mdl_mem[k][i] = dflt(8'(i));
        end
        forever begin
            @(negedge clk);
            model_step(0, 1);
            model_step(1, 3);
        end
    end

    task automatic push(input int k, input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        txq[k*3+i].push_back(t);
    endtask

    task automatic wait_hs(input int k, input int prev, output int t);
        int n = 0;
        t = -100;
        while (hs_cnt[k] == prev && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (hs_cnt[k] == prev) begin
            checks++; errs++;
            $display("FAIL handshake_timeout lane %0d: got none expected grant within 200 cycles", k);
        end else begin
            t = hs_at[k];
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 300) begin
            @(negedge clk); #1; n++;
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((cyc < free_at[k] || txq[k*3].size() + txq[k*3+1].size() + txq[k*3+2].size() > 0) && n < 600) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 600) begin
            checks++; errs++;
            $display("FAIL idle_timeout lane %0d: got busy expected idle within 600 cycles", k);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int t;
        int base;
        int exp_order [9];
        rst_l[0] = 1'b1;
        rst_l[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        env_init = 1'b0;
        @(negedge clk); #1;
        // Reset values
        chk("reset busy", 64'(busy[0]), 64'(0));
        chk("reset mem_en", 64'(mem_en[0]), 64'(0));
        chk("reset grant_id", 64'(gid[0]), 64'(0));
        chk("reset rsp_rdata", 64'(rdata[0]), 64'(0));
        chk("reset mem_addr", 64'(mem_addr[1]), 64'(0));
        @(posedge clk); #1;
        rst_l[0] = 1'b0;
        rst_l[1] = 1'b0;
        @(negedge clk); #1;

        // Single read, MEM_LAT=1
        push(0, 1, 1'b0, 16'h2800, 16'h0000);
        wait_hs(0, hs_cnt[0], t);
        wait_cyc(t + 1);
        chk("rd1 mem_en", 64'(mem_en[0]), 64'(1));
        chk("rd1 mem_addr", 64'(mem_addr[0]), 64'h2800);
        wait_cyc(t + 2);
        chk("rd1 early rsp", 64'(rspv[0]), 64'(0));
        wait_cyc(t + 3);
        chk("rd1 rsp_valid", 64'(rspv[0]), 64'b010);
        chk("rd1 rsp_rdata", 64'(rdata[0]), 64'hBEEF);
        wait_idle(0);

        // Single write, then read it back
        push(0, 0, 1'b1, 16'h0010, 16'h1234);
        wait_hs(0, hs_cnt[0], t);
        wait_cyc(t + 1);
        chk("wr mem_en", 64'(mem_en[0]), 64'(1));
        chk("wr mem_we", 64'(mem_we[0]), 64'(1));
        chk("wr mem_addr", 64'(mem_addr[0]), 64'h0010);
        chk("wr mem_wdata", 64'(mem_wdata[0]), 64'h1234);
        wait_cyc(t + 2);
        chk("wr rsp_valid", 64'(rspv[0]), 64'b001);
        chk("wr rsp_rdata held", 64'(rdata[0]), 64'hBEEF);
        wait_idle(0);
        push(0, 2, 1'b0, 16'h0010, 16'h0000);
        wait_hs(0, hs_cnt[0], t);
        wait_cyc(t + 3);
        chk("rdback rsp_valid", 64'(rspv[0]), 64'b100);
        chk("rdback rsp_rdata", 64'(rdata[0]), 64'h1234);
        wait_idle(0);

        // Contention from reset: all three valid continuously
        @(posedge clk); #1;
        rst_l[0] = 1'b1;
        for (int i = 0; i < 3; i++) push(0, i, 1'b1, 16'(16'h0140 + i), 16'(16'hC000 + i));
        for (int i = 0; i < 3; i++) push(0, i, 1'b0, 16'(16'h0140 + i), 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_l[0] = 1'b0;
        base = glog[0].size();
        wait_idle(0);
        exp_order = '{0, 1, 2, 0, 1, 2, 0, 0, 0};
        for (int n = 0; n < 6; n++) begin
            chk($sformatf("contention grant %0d", n),
                64'((glog[0].size() > base + n) ? glog[0][base + n] : -1), 64'(exp_order[n]));
        end

        // Starvation: req 2 waits behind re-requesting 0 and 1
        push(0, 0, 1'b0, 16'h0200, 16'h0000);
        wait_idle(0);
        for (int n = 0; n < 4; n++) push(0, 0, 1'b0, 16'(16'h0210 + n), 16'h0000);
        for (int n = 0; n < 4; n++) push(0, 1, 1'b0, 16'(16'h0220 + n), 16'h0000);
        push(0, 2, 1'b0, 16'h0230, 16'h0000);
        base = glog[0].size();
        wait_idle(0);
        exp_order = '{1, 2, 0, 1, 0, 1, 0, 1, 0};
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("starve grant %0d", n),
                64'((glog[0].size() > base + n) ? glog[0][base + n] : -1), 64'(exp_order[n]));
        end

        // MEM_LAT=3 read
        push(1, 1, 1'b0, 16'h0033, 16'h0000);
        wait_hs(1, hs_cnt[1], t);
        wait_cyc(t + 1);
        chk("lat3 mem_en", 64'(mem_en[1]), 64'(1));
        chk("lat3 busy t1", 64'(busy[1]), 64'(1));
        for (int n = 2; n <= 4; n++) begin
            wait_cyc(t + n);
            chk($sformatf("lat3 mem_en off t%0d", n), 64'(mem_en[1]), 64'(0));
            chk($sformatf("lat3 busy t%0d", n), 64'(busy[1]), 64'(1));
        end
        wait_cyc(t + 5);
        chk("lat3 rsp_valid", 64'(rspv[1]), 64'b010);
        chk("lat3 rsp_rdata", 64'(rdata[1]), 64'h33CC);
        chk("lat3 busy t5", 64'(busy[1]), 64'(1));
        wait_cyc(t + 6);
        chk("lat3 busy t6", 64'(busy[1]), 64'(0));
        wait_idle(1);

        // Reset during WAIT
        push(1, 2, 1'b0, 16'h0044, 16'h0000);
        wait_hs(1, hs_cnt[1], t);
        wait_cyc(t + 1);
        @(posedge clk); #1;
        rst_l[1] = 1'b1;
        @(posedge clk); #1;
        rst_l[1] = 1'b0;
        @(negedge clk); #1;
        chk("abort busy", 64'(busy[1]), 64'(0));
        chk("abort mem_en", 64'(mem_en[1]), 64'(0));
        chk("abort rsp_valid", 64'(rspv[1]), 64'(0));
        chk("abort grant_id", 64'(gid[1]), 64'(0));
        chk("abort rsp_rdata", 64'(rdata[1]), 64'(0));
        repeat (5) begin
            @(negedge clk); #1;
            chk("abort no rsp", 64'(rspv[1]), 64'(0));
        end
        base = glog[1].size();
        for (int i = 2; i >= 0; i--) push(1, i, 1'b0, 16'(16'h0050 + i), 16'h0000);
        wait_idle(1);
        exp_order = '{0, 1, 2, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("post-reset grant %0d", n),
                64'((glog[1].size() > base + n) ? glog[1][base + n] : -1), 64'(exp_order[n]));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
